// File: rtl/cmp_pkg.sv
// Shared types and defaults for the sliced unsigned magnitude comparator.
package cmp_pkg;

    localparam int unsigned CMP_W_DEFAULT     = 8;
    localparam int unsigned CMP_SLICE_DEFAULT = 4;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
    } cmp_flags_t;

    // Number of slices needed to cover n bits when each slice is w bits wide.
    function automatic int unsigned cmp_num_slices(input int unsigned n, input int unsigned w);
        return (n + w - 1) / w;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one fixed-width slice of the operands.
module cmp_slice
    import cmp_pkg::*;
#(
    parameter int unsigned SLICE_W = CMP_SLICE_DEFAULT
) (
    input  logic [SLICE_W-1:0] a_s,
    input  logic [SLICE_W-1:0] b_s,
    output cmp_flags_t         flags
);

    always_comb begin
        flags    = '0;
        flags.lt = (a_s < b_s);
        flags.gt = (a_s > b_s);
        flags.eq = (a_s == b_s);
    end

endmodule

// File: rtl/nbit_comparator.sv
// Registered N-bit unsigned magnitude comparator built from a cascade of compare slices.
module nbit_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned N       = CMP_W_DEFAULT,
    parameter int unsigned SLICE_W = CMP_SLICE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lesser,
    output logic         greater,
    output logic         equal,
    output logic         out_valid
);

    localparam int unsigned NUM_SLICES = cmp_num_slices(N, SLICE_W);
    localparam int unsigned PAD_W      = NUM_SLICES * SLICE_W;

    // Zero-extension keeps the top slice's padding bits equal on both sides.
    logic [PAD_W-1:0] a_pad;
    logic [PAD_W-1:0] b_pad;

    assign a_pad = PAD_W'(a);
    assign b_pad = PAD_W'(b);

    cmp_flags_t slice_flags [NUM_SLICES];

    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        cmp_slice #(
            .SLICE_W (SLICE_W)
        ) u_slice (
            .a_s   (a_pad[i*SLICE_W +: SLICE_W]),
            .b_s   (b_pad[i*SLICE_W +: SLICE_W]),
            .flags (slice_flags[i])
        );
    end

    // Walk upward so the most-significant unequal slice overrides all below it.
    cmp_flags_t merged;

    always_comb begin
        merged = slice_flags[0];
        for (int unsigned i = 1; i < NUM_SLICES; i++) begin
            if (!slice_flags[i].eq) begin
                merged = slice_flags[i];
            end
        end
    end

    cmp_flags_t flags_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                flags_q <= merged;
            end
        end
    end

    assign lesser    = flags_q.lt;
    assign greater   = flags_q.gt;
    assign equal     = flags_q.eq;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_nbit_comparator.sv
// Scoreboard bench for nbit_comparator at N=8 and N=10 (non-multiple of the slice width).
module tb_nbit_comparator;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       v8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       lt8, gt8, eq8, ov8;

    logic       v10 = 1'b0;
    logic [9:0] a10 = '0;
    logic [9:0] b10 = '0;
    logic       lt10, gt10, eq10, ov10;

    int tests  = 0;
    int failed = 0;

    logic [2:0] q8[$];
    logic [2:0] q10[$];

    always #5 clk = ~clk;

    nbit_comparator #(.N(8), .SLICE_W(4)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .lesser    (lt8),
        .greater   (gt8),
        .equal     (eq8),
        .out_valid (ov8)
    );

    nbit_comparator #(.N(10), .SLICE_W(4)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v10),
        .a         (a10),
        .b         (b10),
        .lesser    (lt10),
        .greater   (gt10),
        .equal     (eq10),
        .out_valid (ov10)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for one DUT: pops on out_valid, otherwise checks that flags hold.
    task automatic monitor_step(input string tag, input logic ov, input logic [2:0] f,
                                inout logic [2:0] last, inout logic [2:0] q[$]);
        logic [2:0] exp;
        if (!rst_n) begin
            chk({tag, " reset"}, {ov, f}, 4'b0000);
            last = 3'b000;
        end else if (ov) begin
            if (q.size() == 0) begin
                chk({tag, " unexpected out_valid"}, {ov, f}, 4'b0000);
            end else begin
                exp = q.pop_front();
                chk({tag, " flags"}, {ov, f}, {1'b1, exp});
                chk({tag, " onehot"}, {3'b000, $onehot(f)}, 4'b0001);
                last = exp;
            end
        end else begin
            chk({tag, " hold"}, {ov, f}, {1'b0, last});
        end
    endtask

    initial begin : mon
        logic [2:0] last8;
        logic [2:0] last10;
        last8  = 3'b000;
        last10 = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            monitor_step("n8", ov8, {lt8, gt8, eq8}, last8, q8);
            monitor_step("n10", ov10, {lt10, gt10, eq10}, last10, q10);
        end
    end

    task automatic drv8(input logic [7:0] x, input logic [7:0] y, input logic [2:0] e);
        @(negedge clk);
        a8 = x;
        b8 = y;
        v8 = 1'b1;
        q8.push_back(e);
    endtask

    task automatic drv10(input logic [9:0] x, input logic [9:0] y, input logic [2:0] e);
        @(negedge clk);
        a10 = x;
        b10 = y;
        v10 = 1'b1;
        q10.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v8  = 1'b0;
            v10 = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] e;
    } vec8_t;

    vec8_t vecs[$] = '{
        '{8'd147, 8'd103, GT}, '{8'd199, 8'd220, LT}, '{8'd137, 8'd171, LT},
        '{8'd85,  8'd25,  GT}, '{8'd21,  8'd50,  LT}, '{8'd79,  8'd74,  GT},
        '{8'd255, 8'd255, EQ}, '{8'd169, 8'd169, EQ}, '{8'd96,  8'd96,  EQ},
        '{8'd0,   8'd0,   EQ}, '{8'd0,   8'd255, LT}, '{8'd255, 8'd0,   GT},
        '{8'h10,  8'h0F,  GT}, '{8'h3A,  8'h3B,  LT}
    };

    initial begin : stim
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] e;

        // Held in reset across a few edges: monitor expects all zero.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        drv8(8'd111, 8'd250, LT);
        idle(2);

        foreach (vecs[i]) drv8(vecs[i].x, vecs[i].y, vecs[i].e);
        idle(2);

        // Reset mid-stream while a compare is pending: it must be discarded.
        drv8(8'd147, 8'd103, GT);
        #2;
        rst_n = 1'b0;
        q8.delete();
        #1;
        chk("async reset n8", {ov8, lt8, gt8, eq8}, 4'b0000);
        chk("async reset n10", {ov10, lt10, gt10, eq10}, 4'b0000);
        v8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drv8(8'd85, 8'd25, GT);
        idle(2);

        drv10(10'd1023, 10'd1022, GT);
        drv10(10'd512, 10'd511, GT);
        drv10(10'd1000, 10'd1000, EQ);
        drv10(10'd3, 10'd768, LT);
        idle(1);

        for (int i = 0; i < 1000; i++) begin
            x = 10'($urandom);
            y = ($urandom_range(3) == 0) ? x : 10'($urandom);
            e = {x < y, x > y, x == y};
            if ($urandom_range(4) == 0) begin
                idle(1);
            end
            drv10(x, y, e);
        end
        idle(3);

        chk("n8 queue drained", 4'(q8.size()), 4'd0);
        chk("n10 queue drained", 4'(q10.size()), 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/nbit_comparator.md
Name: nbit_comparator

Overview:
Parameterised unsigned magnitude comparator for two N-bit operands. It produces one-hot lesser/greater/equal flags, registered with one cycle of latency. It is used as a datapath utility wherever a registered relational result is needed, for example in arbitration, threshold detection or sort networks. Internally the compare is a cascade of fixed-width slices combined from the MSB slice down.

Parameters:
- N, 8, operand width in bits (≥1; any value, not only multiples of the slice width)
- SLICE_W, 4, width of each internal compare slice (1..N)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b are to be compared this cycle
- a  input  N  operand A, unsigned
- b  input  N  operand B, unsigned
- lesser  output  1  registered: a < b
- greater  output  1  registered: a > b
- equal  output  1  registered: a == b
- out_valid  output  1  registered: flags reflect a compare captured on the previous edge

Behaviour:
- Reset (rst_n low, asynchronous): lesser=0, greater=0, equal=0, out_valid=0. This is held while rst_n is low. The first capture occurs on the first rising edge after rst_n rises.
- Compare is unsigned magnitude over all N bits.
- Combinational result: exactly one of lt/gt/eq is true for any a,b.
- On a rising edge with in_valid=1: load lesser/greater/equal from the combinational result of the current a,b, and set out_valid=1. Latency is 1 clock. One compare is accepted per cycle, with no back-pressure.
- On a rising edge with in_valid=0: lesser/greater/equal hold their last values, and out_valid=0.
- After any valid capture, exactly one flag is 1. Between reset and the first capture, all flags are 0.
- Reset asserted mid-stream: all outputs clear immediately, and any pending compare is discarded.
- Operand X/Z handling is not specified. Operands must be known whenever in_valid=1.
- Width handling: operands are zero-extended internally to ceil(N/SLICE_W)*SLICE_W bits. The extension must not change the result.
- Slice cascade:
  - Each slice outputs its own lt/gt/eq.
  - The final result is decided by the most-significant slice whose eq=0.
  - If all slices have eq=1, the result is equal.

Decomposition:
- Shared package cmp_pkg:
  - default width constant CMP_W_DEFAULT=8
  - default slice width CMP_SLICE_DEFAULT=4
  - a packed struct cmp_flags_t {lt, gt, eq} used for the slice outputs and the output register
- One sub-module, cmp_slice:
  - purely combinational, parameterised by SLICE_W
  - inputs: a_s, b_s
  - output: cmp_flags_t
  - the top instantiates it with a generate loop and contains the MSB-priority merge and the output registers

Test Plan:
- Reset, then a=111,b=250 with in_valid=1 for one cycle. Next edge: lesser=1, greater=0, equal=0, out_valid=1. The following cycle with in_valid=0: out_valid=0 and the flags hold.
- Back-to-back valid vectors, each checked one cycle after it is applied:
  - 147/103 → greater
  - 199/220 → lesser
  - 137/171 → lesser
  - 85/25 → greater
  - 21/50 → lesser
  - 79/74 → greater
- Equality and extremes:
  - 255/255 → equal
  - 169/169 → equal
  - 96/96 → equal
  - 0/0 → equal
  - 0/255 → lesser
  - 255/0 → greater
- Slice boundary: 0x10 vs 0x0F → greater (decided by the upper slice). 0x3A vs 0x3B → lesser (upper slices equal, decided by the lower slice).
- Assert rst_n low asynchronously mid-stream, away from a clock edge → all outputs 0 immediately. After release, 85/25 valid → greater on the next edge.
- N=10, SLICE_W=4 (non-multiple width): 1023/1022 → greater; 512/511 → greater; 1000/1000 → equal. Plus 1000 random vectors checked against a reference model, with the one-hot flags asserted on every valid output.
